alu_arbiter: RTL and testbench

//  Shares one combinational alu instance (ports a,b,op,y,carry,overflow,zero,negative)

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters,
// with a registered, backpressurable response channel tagged by requester id.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int SW = $clog2(WIDTH);
  logic             sub, arith;
  logic [WIDTH-1:0] bx, sra;
  logic [WIDTH:0]   sum;
  assign sra = $signed(a) >>> b[SW-1:0];
  always_comb begin
    sub      = op == 4'h1;
    arith    = op == 4'h0 || sub;
    bx       = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
    y        = arith      ? sum[WIDTH-1:0] :
               op == 4'h2 ? a & b :
               op == 4'h3 ? a | b :
               op == 4'h4 ? a ^ b :
               op == 4'h5 ? a << b[SW-1:0] :
               op == 4'h6 ? a >> b[SW-1:0] :
               op == 4'h7 ? sra : '0;
    carry    = arith & sum[WIDTH];
    overflow = arith & (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    zero     = y == '0;
    negative = y[WIDTH-1];
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_carry,
  output logic             resp_overflow,
  output logic             resp_zero,
  output logic             resp_negative,
  output logic             resp_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d, id_q, id_d, rv_q, rv_d, rid_q, rid_d;
  logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d, err_q, err_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, alu_y;
  logic             alu_c, alu_v, alu_z, alu_n, gnt, acc, exec, ill;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op(op_q), .a(a_q), .b(b_q), .y(alu_y),
    .carry(alu_c), .overflow(alu_v), .zero(alu_z), .negative(alu_n)
  );

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    acc = state_q == IDLE && (gnt ? req1_valid : req0_valid);
  end

  always_comb begin
    state_d = state_q == IDLE ? (acc ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              (resp_ready ? IDLE : RESP);
  end

  always_comb begin
    req0_ready = state_q == IDLE && !gnt;
    req1_ready = state_q == IDLE && gnt;
    busy       = state_q != IDLE;
  end

  always_comb begin
    exec   = state_q == EXEC;
    ill    = op_q[3];
    last_d = acc ? gnt : last_q;
    id_d   = acc ? gnt : id_q;
    op_d   = acc ? (gnt ? req1_op : req0_op) : op_q;
    a_d    = acc ? (gnt ? req1_a : req0_a) : a_q;
    b_d    = acc ? (gnt ? req1_b : req0_b) : b_q;
    rv_d   = exec | (rv_q & ~resp_ready);
    rid_d  = exec ? id_q : rid_q;
    y_d    = exec ? (ill ? '0 : alu_y) : y_q;
    c_d    = exec ? alu_c & ~ill : c_q;
    v_d    = exec ? alu_v & ~ill : v_q;
    z_d    = exec ? alu_z & ~ill : z_q;
    n_d    = exec ? alu_n & ~ill : n_q;
    err_d  = exec ? ill : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rv_q    <= 1'b0;
      rid_q   <= 1'b0;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      y_q     <= y_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid    = rv_q;
  assign resp_id       = rid_q;
  assign resp_y        = y_q;
  assign resp_carry    = c_q;
  assign resp_overflow = v_q;
  assign resp_zero     = z_q;
  assign resp_negative = n_q;
  assign resp_err      = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random transactions against an arithmetic reference model.
module tb_alu_arbiter;
  localparam int W = 32;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b1;
  logic [3:0]    req0_op = '0, req1_op = '0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_ready, req1_ready, resp_valid, resp_id, busy;
  logic [W-1:0]  resp_y;
  logic          resp_carry, resp_overflow, resp_zero, resp_negative, resp_err;
  logic [36:0]   rsp;
  int            total = 0, bad = 0;
  logic          last_m = 1'b1;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_y(resp_y),
    .resp_carry(resp_carry), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
    .resp_negative(resp_negative), .resp_err(resp_err), .busy(busy)
  );

  assign rsp = {resp_err, resp_negative, resp_zero, resp_overflow, resp_carry, resp_y};
  always #5 clk = ~clk;

  // Returns {err, N, Z, V, C, y} from plain integer arithmetic.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] y;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    y = '0;
    if (op > 4'd7) return {1'b1, 36'b0};
    case (op)
      4'd0: begin y = a + b; c = ((longint'(a) + longint'(b)) >> 32) != 0; s = sa + sb; v = longint'(int'(s)) != s; end
      4'd1: begin y = a - b; c = a >= b; s = sa - sb; v = longint'(int'(s)) != s; end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = a << b[4:0];
      4'd6: y = a >> b[4:0];
      default: y = 32'($signed(a) >>> b[4:0]);
    endcase
    return {1'b0, y[31], y == 32'h0, v, c, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [36:0] e;
    e = model(op, a, b);
    req0_valid = !k; req1_valid = k;
    if (k) begin req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_op = op; req0_a = a; req0_b = b; end
    resp_ready = (hold == 0);
    #1;
    chk("grant", {req0_ready, req1_ready}, {!k, k});
    tick();
    last_m = k;
    req0_valid = 0; req1_valid = 0;
    req0_op = 4'($urandom); req1_op = 4'($urandom);
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    chk("exec_busy", busy, 1);
    chk("exec_rv", resp_valid, 0);
    tick();
    chk("resp_rv", resp_valid, 1);
    chk("resp_id", resp_id, k);
    chk("resp_data", rsp, e);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_rv", resp_valid, 1);
      chk("bp_id", resp_id, k);
      chk("bp_data", rsp, e);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    resp_ready = 1;
    tick();
    chk("back_idle", {resp_valid, busy}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", rsp, 0);
    chk("rst_ctl", {resp_valid, resp_id, busy}, 0);
    rst_n = 1;
    tick();
    txn(0, 4'h5, 32'h1, 32'h4, 0);
    chk("t1_y", resp_y, 32'h10);
    txn(1, 4'h7, 32'hFFFF_FFE0, 32'h3, 0);
    chk("t2_nz", {resp_y, resp_negative, resp_zero}, {32'hFFFF_FFFC, 2'b10});
    txn(0, 4'h6, 32'h80, 32'h1, 5);
    txn(1, 4'h9, 32'h1234, 32'h5678, 0);
    chk("err_set", {resp_err, rsp[35:0]}, {1'b1, 36'b0});
    txn(0, 4'h0, 32'h7FFF_FFFF, 32'h1, 0);
    chk("err_clear", resp_err, 0);
    txn(1, 4'h0, 32'hFFFF_FFFF, 32'h1, 1);
    txn(0, 4'h1, 32'h0, 32'h1, 0);
    txn(1, 4'h1, 32'h8000_0000, 32'h1, 0);
    for (int i = 0; i < 24; i++)
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), $urandom, $urandom, $urandom_range(0, 2));
    // Fairness with both requesters held valid.
    req0_valid = 1; req1_valid = 1; resp_ready = 1;
    req0_op = 4'h6; req1_op = 4'h6;
    req0_a = 32'h10; req1_a = 32'h10; req0_b = 32'h2; req1_b = 32'h2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {req0_ready, req1_ready}, {last_m, !last_m});
      last_m = !last_m;
      tick();
      chk("rr_exec_ready", {req0_ready, req1_ready}, 0);
      tick();
      chk("rr_resp", {resp_valid, resp_id, resp_y}, {1'b1, last_m, 32'h4});
      chk("rr_resp_ready", {req0_ready, req1_ready}, 0);
      tick();
    end
    req1_valid = 0;
    req0_op = 4'h5; req0_a = 32'h3; req0_b = 32'h1;
    tick();
    req0_valid = 0;
    chk("rst_exec_state", busy, 1);
    rst_n = 0;
    #1;
    chk("rst_exec_out", {resp_valid, resp_id, busy, rsp}, 0);
    rst_n = 1;
    tick();
    tick();
    chk("rst_exec_noresp", {resp_valid, busy}, 0);
    last_m = 1;
    req0_valid = 1; resp_ready = 0;
    tick();
    req0_valid = 0;
    tick();
    chk("rst_resp_state", {resp_valid, resp_y}, {1'b1, 32'h6});
    rst_n = 0;
    #1;
    chk("rst_resp_out", {resp_valid, resp_id, busy, rsp}, 0);
    rst_n = 1;
    resp_ready = 1;
    tick();
    chk("rst_resp_noresp", resp_valid, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rst_tie", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 0; req1_valid = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
